// File: rtl/avl_st_pkt_sink.sv
// Avalon-ST packet sink: consumes a stream under a programmable ready pattern,
// checks SOP/EOP framing and keeps packet, beat and error statistics.
module avl_st_pkt_sink #(
   parameter int          DATA_WIDTH = 32,
   parameter int          CNT_WIDTH  = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic                  in_startofpacket,
   input  logic                  in_endofpacket,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic [1:0]            bp_mode,
   input  logic                  clear,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic [CNT_WIDTH-1:0]  beat_count,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [CNT_WIDTH-1:0]  last_len,
   output logic [DATA_WIDTH-1:0] last_sum,
   output logic                  pkt_done,
   output logic                  in_packet
);

   typedef enum logic {IDLE, IN_PKT} state_t;

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t                state;
   logic [15:0]           lfsr;
   logic                  toggle;
   logic [CNT_WIDTH-1:0]  acc_len;
   logic [DATA_WIDTH-1:0] acc_sum;
   logic                  xfer;
   logic                  lfsr_fb;

   assign xfer      = in_valid & in_ready;
   assign in_packet = (state == IN_PKT);
   assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   // Ready generation runs free of clear so the bus pattern is never disturbed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_ready <= 1'b0;
         lfsr     <= LFSR_SEED;
         toggle   <= 1'b0;
      end else begin
         lfsr   <= {lfsr_fb, lfsr[15:1]};
         toggle <= ~toggle;
         case (bp_mode)
            2'b00:   in_ready <= 1'b1;
            2'b01:   in_ready <= lfsr[0];
            2'b10:   in_ready <= 1'b0;
            default: in_ready <= ~toggle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         pkt_count  <= '0;
         beat_count <= '0;
         err_count  <= '0;
         last_len   <= '0;
         last_sum   <= '0;
         pkt_done   <= 1'b0;
         acc_len    <= '0;
         acc_sum    <= '0;
      end else begin
         pkt_done <= 1'b0;
         if (clear) begin
            state      <= IDLE;
            pkt_count  <= '0;
            beat_count <= '0;
            err_count  <= '0;
            last_len   <= '0;
            last_sum   <= '0;
         end else if (xfer) begin
            beat_count <= sat_inc(beat_count);
            if (in_startofpacket) begin
               // SOP inside an open packet abandons it and restarts framing here.
               if (state == IN_PKT) err_count <= sat_inc(err_count);
               if (in_endofpacket) begin
                  last_len  <= ONE;
                  last_sum  <= in_data;
                  pkt_count <= sat_inc(pkt_count);
                  pkt_done  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  acc_len <= ONE;
                  acc_sum <= in_data;
                  state   <= IN_PKT;
               end
            end else if (state == IDLE) begin
               err_count <= sat_inc(err_count);
            end else if (in_endofpacket) begin
               last_len  <= sat_inc(acc_len);
               last_sum  <= acc_sum + in_data;
               pkt_count <= sat_inc(pkt_count);
               pkt_done  <= 1'b1;
               state     <= IDLE;
            end else begin
               acc_len <= sat_inc(acc_len);
               acc_sum <= acc_sum + in_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_avl_st_pkt_sink.sv
// Directed and randomized bench for avl_st_pkt_sink against a transaction-level
// model of the framing rules, ready patterns and statistics.
module tb_avl_st_pkt_sink;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, sop, eop, clear;
   logic [31:0] in_data;
   logic [1:0]  bp_mode;

   logic        in_ready, pkt_done, in_packet;
   logic [15:0] pkt_count, beat_count, err_count, last_len;
   logic [31:0] last_sum;

   logic        in_ready4, pkt_done4, in_packet4;
   logic [3:0]  pkt_count4, beat_count4, err_count4, last_len4;
   logic [31:0] last_sum4;

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   avl_st_pkt_sink dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_startofpacket(sop),
      .in_endofpacket(eop), .in_data(in_data), .in_ready(in_ready), .bp_mode(bp_mode),
      .clear(clear), .pkt_count(pkt_count), .beat_count(beat_count), .err_count(err_count),
      .last_len(last_len), .last_sum(last_sum), .pkt_done(pkt_done), .in_packet(in_packet));

   avl_st_pkt_sink #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_startofpacket(sop),
      .in_endofpacket(eop), .in_data(in_data), .in_ready(in_ready4), .bp_mode(bp_mode),
      .clear(clear), .pkt_count(pkt_count4), .beat_count(beat_count4), .err_count(err_count4),
      .last_len(last_len4), .last_sum(last_sum4), .pkt_done(pkt_done4), .in_packet(in_packet4));

   // Reference model: counters kept as plain integers, clipped at the 16-bit ceiling.
   int          m_pkts, m_beats, m_errs, m_len, m_cur_len;
   logic [31:0] m_sum, m_cur_sum;
   bit          m_inpkt, m_done, m_ready, m_tog;
   logic [15:0] m_lfsr;

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic [15:0] b;
      b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h1;
      return (l >> 1) | (b << 15);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pkts <= 0; m_beats <= 0; m_errs <= 0; m_len <= 0; m_sum <= '0;
         m_cur_len <= 0; m_cur_sum <= '0; m_inpkt <= 0; m_done <= 0;
         m_ready <= 0; m_tog <= 0; m_lfsr <= 16'hACE1;
      end else begin
         m_lfsr  <= lfsr_next(m_lfsr);
         m_tog   <= ~m_tog;
         m_ready <= (bp_mode == 2'd0) ? 1'b1 : (bp_mode == 2'd1) ? m_lfsr[0] :
                    (bp_mode == 2'd2) ? 1'b0 : ~m_tog;
         m_done  <= 0;
         if (clear) begin
            m_pkts <= 0; m_beats <= 0; m_errs <= 0; m_len <= 0; m_sum <= '0; m_inpkt <= 0;
         end else if (in_valid && m_ready) begin
            m_beats <= sat(m_beats + 1);
            if (sop) begin
               if (m_inpkt) m_errs <= sat(m_errs + 1);
               if (eop) begin
                  m_len <= 1; m_sum <= in_data; m_pkts <= sat(m_pkts + 1);
                  m_done <= 1; m_inpkt <= 0;
               end else begin
                  m_cur_len <= 1; m_cur_sum <= in_data; m_inpkt <= 1;
               end
            end else if (!m_inpkt) begin
               m_errs <= sat(m_errs + 1);
            end else if (eop) begin
               m_len <= sat(m_cur_len + 1); m_sum <= m_cur_sum + in_data;
               m_pkts <= sat(m_pkts + 1); m_done <= 1; m_inpkt <= 0;
            end else begin
               m_cur_len <= sat(m_cur_len + 1); m_cur_sum <= m_cur_sum + in_data;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pkt_count"},  32'(pkt_count),  32'(m_pkts));
      chk({tag, ".beat_count"}, 32'(beat_count), 32'(m_beats));
      chk({tag, ".err_count"},  32'(err_count),  32'(m_errs));
      chk({tag, ".last_len"},   32'(last_len),   32'(m_len));
      chk({tag, ".last_sum"},   last_sum,        m_sum);
      chk({tag, ".pkt_done"},   32'(pkt_done),   32'(m_done));
      chk({tag, ".in_packet"},  32'(in_packet),  32'(m_inpkt));
      chk({tag, ".in_ready"},   32'(in_ready),   32'(m_ready));
   endtask

   // Called at a negedge; holds the beat until it is accepted, returns at the following negedge.
   task automatic beat(input bit s, input bit e, input logic [31:0] d, input string tag);
      bit took = 0;
      in_valid = 1; sop = s; eop = e; in_data = d;
      for (int i = 0; i < 100 && !took; i++) begin
         took = in_ready;
         @(posedge clk); @(negedge clk);
      end
      in_valid = 0; sop = 0; eop = 0;
      if (!took) chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
      check_all(tag);
   endtask

   task automatic pulse_clear();
      clear = 1; @(posedge clk); @(negedge clk); clear = 0;
   endtask

   initial begin
      reset_n = 0; in_valid = 0; sop = 0; eop = 0; in_data = '0; bp_mode = 2'd0; clear = 0;
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.pkt_count", 32'(pkt_count), 32'd0);
      chk("rst.pkt_done", 32'(pkt_done), 32'd0);
      chk("rst.in_packet", 32'(in_packet), 32'd0);
      @(negedge clk); reset_n = 1;
      chk("rel.in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("rel.in_ready_high", 32'(in_ready), 32'd1);

      // 4-beat packet 1..4
      beat(1, 0, 1, "p4.b1"); beat(0, 0, 2, "p4.b2"); beat(0, 0, 3, "p4.b3");
      beat(0, 1, 4, "p4.b4");
      chk("p4.pkt_count", 32'(pkt_count), 32'd1);
      chk("p4.beat_count", 32'(beat_count), 32'd4);
      chk("p4.last_len", 32'(last_len), 32'd4);
      chk("p4.last_sum", last_sum, 32'd10);
      chk("p4.pkt_done", 32'(pkt_done), 32'd1);
      @(negedge clk);
      chk("p4.pkt_done_drop", 32'(pkt_done), 32'd0);
      chk("p4.err_count", 32'(err_count), 32'd0);

      // single beat then wrapping 2-beat sum
      beat(1, 1, 32'hFFFF_FFFF, "wrap.single");
      chk("wrap.single_sum", last_sum, 32'hFFFF_FFFF);
      beat(1, 0, 32'hFFFF_FFFF, "wrap.b1"); beat(0, 1, 32'h2, "wrap.b2");
      chk("wrap.last_len", 32'(last_len), 32'd2);
      chk("wrap.last_sum", last_sum, 32'h1);
      chk("wrap.pkt_count", 32'(pkt_count), 32'd3);

      // framing errors
      pulse_clear();
      check_all("clr");
      beat(0, 0, 9, "fe.nosop"); beat(1, 0, 1, "fe.sop1"); beat(0, 0, 2, "fe.mid");
      beat(1, 0, 3, "fe.sop2"); beat(0, 1, 4, "fe.eop");
      chk("fe.err_count", 32'(err_count), 32'd2);
      chk("fe.pkt_count", 32'(pkt_count), 32'd1);
      chk("fe.last_len", 32'(last_len), 32'd2);
      chk("fe.last_sum", last_sum, 32'd7);
      chk("fe.beat_count", 32'(beat_count), 32'd5);

      // alternate mode with valid held, then never-ready
      bp_mode = 2'd3; in_valid = 1; sop = 1; eop = 1; in_data = 32'h55;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         check_all("alt");
      end
      bp_mode = 2'd2;
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("never.in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); @(negedge clk);
      end
      check_all("never");
      in_valid = 0; sop = 0; eop = 0;

      // LFSR mode with fully random traffic
      bp_mode = 2'd1;
      for (int i = 0; i < 1000; i++) begin
         in_valid = 1'($urandom); sop = ($urandom_range(0, 3) == 0);
         eop = ($urandom_range(0, 2) == 0); in_data = $urandom;
         @(posedge clk); @(negedge clk);
         chk("lfsr.in_ready", 32'(in_ready), 32'(m_ready));
         if (i % 100 == 99) check_all("lfsr");
      end
      in_valid = 0; sop = 0; eop = 0;
      bp_mode = 2'd0;
      @(negedge clk);

      // saturation on the 4-bit instance
      pulse_clear();
      for (int i = 0; i < 20; i++) beat(1, 1, 32'(i), "sat");
      chk("sat.pkt_count4", 32'(pkt_count4), 32'd15);
      chk("sat.beat_count4", 32'(beat_count4), 32'd15);
      chk("sat.last_len4", 32'(last_len4), 32'd1);
      chk("sat.pkt_count16", 32'(pkt_count), 32'd20);

      // clear on the EOP beat
      pulse_clear();
      beat(1, 0, 5, "ce.b1"); beat(0, 0, 6, "ce.b2");
      in_valid = 1; eop = 1; in_data = 7; clear = 1;
      @(posedge clk); @(negedge clk);
      in_valid = 0; eop = 0; clear = 0;
      chk("ce.pkt_count", 32'(pkt_count), 32'd0);
      chk("ce.beat_count", 32'(beat_count), 32'd0);
      chk("ce.in_packet", 32'(in_packet), 32'd0);
      chk("ce.pkt_done", 32'(pkt_done), 32'd0);
      @(negedge clk);
      chk("ce.pkt_done_next", 32'(pkt_done), 32'd0);
      check_all("ce");

      // reset mid-packet
      beat(1, 0, 1, "rm.b1"); beat(0, 0, 2, "rm.b2");
      reset_n = 0; #1;
      chk("rm.in_packet", 32'(in_packet), 32'd0);
      chk("rm.beat_count", 32'(beat_count), 32'd0);
      chk("rm.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk); reset_n = 1;
      beat(1, 0, 10, "rm.p1"); beat(0, 0, 20, "rm.p2"); beat(0, 1, 30, "rm.p3");
      chk("rm.pkt_count", 32'(pkt_count), 32'd1);
      chk("rm.last_len", 32'(last_len), 32'd3);
      chk("rm.last_sum", last_sum, 32'd60);
      chk("rm.err_count", 32'(err_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/avl_st_pkt_sink.md
Name: avl_st_pkt_sink

Overview:
- Avalon-ST packet receiver on the `dst` end of the mini streaming interface (ready, valid, startofpacket, endofpacket, data).
- Consumes the stream with a programmable backpressure pattern on ready.
- Checks packet framing and reports packet, beat and error statistics plus the per-packet length and checksum.
- Sits at the end of a source or DUT in the bus testbenches, as the hardware counterpart to a stream driver.

Parameters:
- DATA_WIDTH, 32, width of data.
- CNT_WIDTH, 16, width of all statistic counters and of last_len.
- LFSR_SEED, 16'hACE1, reset value of the backpressure LFSR; must be nonzero.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  source asserts a valid beat.
- in_startofpacket  input  1  first beat of a packet.
- in_endofpacket  input  1  last beat of a packet.
- in_data  input  DATA_WIDTH  beat payload.
- in_ready  output  1  sink can accept; registered.
- bp_mode  input  2  backpressure mode: 00 always ready, 01 LFSR random, 10 never ready, 11 alternate.
- clear  input  1  synchronous statistics/FSM clear pulse.
- pkt_count  output  CNT_WIDTH  good packets completed.
- beat_count  output  CNT_WIDTH  all accepted beats.
- err_count  output  CNT_WIDTH  framing errors.
- last_len  output  CNT_WIDTH  beat count of the last completed packet.
- last_sum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of the last completed packet's data.
- pkt_done  output  1  one-cycle pulse per completed packet.
- in_packet  output  1  FSM is in IN_PKT.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - in_ready=0; all counters, last_len, last_sum, pkt_done=0.
  - FSM=IDLE; LFSR=LFSR_SEED; alternate toggle=0.
- Handshake:
  - Transfer = in_valid & in_ready in the same cycle (readyLatency 0).
  - Inputs are ignored when no transfer occurs.
- in_ready is registered and its next value is selected by bp_mode:
  - 00: 1.
  - 01: LFSR bit 0.
  - 10: 0.
  - 11: inverse of the current toggle.
  - Consequence: in_ready is first 1 after the first clock edge following reset release (modes 00/01/11).
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every cycle regardless of mode.
  - Not affected by clear.
- FSM IDLE, per transfer:
  - SOP & EOP: single-beat packet completes (len=1, sum=data); stay IDLE.
  - SOP & !EOP: start packet with acc_len=1, acc_sum=data; go to IN_PKT.
  - !SOP: framing error, err_count+1; beat discarded from length/sum; stay IDLE.
- FSM IN_PKT, per transfer:
  - SOP: framing error, err_count+1; the open packet is abandoned (no pkt_done); restart with acc_len=1, acc_sum=data. If EOP is also set, it completes as a single-beat packet and the FSM goes to IDLE; otherwise it stays in IN_PKT.
  - !SOP & EOP: acc_len+1 and acc_sum+data; packet completes; go to IDLE.
  - !SOP & !EOP: accumulate; stay in IN_PKT.
- Packet completion, on the clock edge of the final beat:
  - last_len and last_sum are loaded.
  - pkt_count increments.
  - pkt_done=1 for exactly the following cycle.
- beat_count increments on every transfer, including error beats.
- Arithmetic:
  - All counters and acc_len saturate at 2^CNT_WIDTH-1; no wrap.
  - acc_sum wraps modulo 2^DATA_WIDTH.
- clear=1:
  - Next edge zeroes counters, last_len, last_sum and pkt_done; FSM goes to IDLE.
  - A same-cycle transfer is accepted on the bus but dropped from all statistics.
  - in_ready and the LFSR are unaffected.
- Reset mid-packet: everything returns to reset values immediately; the partial packet is lost.
- Beats held with valid while in_ready=0 are not consumed; the sink places no stability requirement on data.

Test Plan:
- bp_mode=00; packet of 4 beats, data 1,2,3,4, SOP on beat 1, EOP on beat 4 → pkt_count=1, beat_count=4, last_len=4, last_sum=10, a single pkt_done pulse, err_count=0.
- bp_mode=00; single beat SOP+EOP with data 0xFFFFFFFF, then a 2-beat packet 0xFFFFFFFF,0x2 → last_len=2, last_sum=0x1 (wrap), pkt_count=2.
- bp_mode=00; beat without SOP in IDLE, then SOP,data,SOP,EOP (4 beats) → err_count=2, pkt_count=1, last_len=2, beat_count=5.
- bp_mode=11 then 10 with valid held high → in_ready alternates 1,0,1,0; mode 10 gives in_ready=0 from the next cycle and beat_count frozen. bp_mode=01 over 1000 cycles gives an in_ready sequence matching the reference LFSR model seeded 0xACE1.
- Counter saturation: CNT_WIDTH=4, 20 single-beat packets → pkt_count=15, beat_count=15.
- reset_n low mid-packet (after 2 of 4 beats), then release and send a full 3-beat packet → counters restart from 0, pkt_count=1, last_len=3, no error. Separately, clear asserted on an EOP beat → stats 0, FSM IDLE, no pkt_done.
